encoder_16to4_serial: RTL and testbench

- Inverse-direction companion to the 4-to-16 decoder: accepts a 16-bit multi-hot request vector and emits the 4-bit binary index of every set bit, one index per beat, lowest index first.
- Input and output both use valid/ready handshakes, so the block drops between a request/flag producer and any consumer of binary indices.
- Feeding each output index through the 4-to-16 decoder and ORing the results reconstructs the accepted vector.

---
 rtl/encoder_16to4_serial.sv | 92 +++++++++
 tb/tb_encoder_16to4_serial.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_16to4_serial.sv
// Serialises a 16-bit multi-hot vector into one 4-bit index per beat, lowest index first.
// Latency: the first beat appears 1 cycle after accept, then 1 beat per cycle; 1-cycle bubble between vectors.
// Backpressure: beats hold stable while out_ready is low; in_ready is high only in IDLE.
module encoder_16to4_serial #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] a,
    output logic             last,
    output logic             none
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic             zero_flag, zero_nxt;
    logic [IDX_W-1:0] low_idx;
    logic [WIDTH-1:0] pending_cleared;
    logic             at_most_one;

    // Priority scan: the last assignment wins, so the scan runs top-down to land on the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign pending_cleared = pending & (pending - WIDTH'(1));
    assign at_most_one     = (pending_cleared == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            zero_flag <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        zero_nxt    = zero_flag;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        a           = '0;
        last        = 1'b0;
        none        = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pending_nxt = d;
                    zero_nxt    = (d == '0);
                    state_nxt   = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                none      = zero_flag;
                last      = zero_flag | at_most_one;
                a         = zero_flag ? '0 : low_idx;
                if (out_ready) begin
                    pending_nxt = pending_cleared;
                    if (last) begin
                        state_nxt = IDLE;
                        zero_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_encoder_16to4_serial.sv
// Directed bench for encoder_16to4_serial: inputs are driven and outputs sampled on the falling edge.
module tb_encoder_16to4_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] d = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  a;
    logic        last;
    logic        none;

    int total = 0;
    int bad   = 0;

    encoder_16to4_serial dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d        (d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a        (a),
        .last     (last),
        .none     (none)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dec4to16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a vector at the falling edge, confirm it is accepted at the next rising edge.
    task automatic accept(input logic [15:0] vec, input logic keep_valid);
        d        = vec;
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_in_ready vec=%h got=%b exp=1", vec, in_ready);
        end
        step();
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({out_valid, a, last, none} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000000", {out_valid, a, last, none});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        accept(16'h0001, 1'b0);
        total++;
        if ({out_valid, a, last, none, in_ready} !== {1'b1, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL single_beat v=%b a=%0d last=%b none=%b rdy=%b exp 1/0/1/0/0",
                     out_valid, a, last, none, in_ready);
        end
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_return in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_multi();
        logic [3:0] exp_a [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        int low_cycles = 0;
        out_ready = 1'b1;
        accept(16'h8421, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (in_ready === 1'b0) low_cycles++;
            total++;
            if (out_valid !== 1'b1 || a !== exp_a[i] || last !== (i == 3) || none !== 1'b0) begin
                bad++;
                $display("FAIL multi_beat%0d v=%b a=%0d last=%b none=%b exp 1/%0d/%0d/0",
                         i, out_valid, a, last, none, exp_a[i], (i == 3));
            end
            step();
        end
        if (in_ready === 1'b0) low_cycles++;
        total++;
        if (low_cycles != 4) begin
            bad++;
            $display("FAIL multi_ready_low got=%0d exp=4", low_cycles);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        accept(16'h0300, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || a !== 4'd8 || last !== 1'b0 || none !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d v=%b a=%0d last=%b none=%b exp 1/8/0/0",
                         i, out_valid, a, last, none);
            end
            step();
        end
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b1 || a !== 4'd8 || last !== 1'b0) begin
            bad++;
            $display("FAIL bp_beat8 v=%b a=%0d last=%b exp 1/8/0", out_valid, a, last);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || a !== 4'd9 || last !== 1'b1) begin
            bad++;
            $display("FAIL bp_beat9 v=%b a=%0d last=%b exp 1/9/1", out_valid, a, last);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_done v=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        accept(16'h0000, 1'b0);
        total++;
        if (out_valid !== 1'b1 || none !== 1'b1 || a !== 4'd0 || last !== 1'b1) begin
            bad++;
            $display("FAIL zero_beat v=%b none=%b a=%0d last=%b exp 1/1/0/1", out_valid, none, a, last);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || none !== 1'b0) begin
            bad++;
            $display("FAIL zero_idle v=%b rdy=%b none=%b exp 0/1/0", out_valid, in_ready, none);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] recon = '0;
        out_ready = 1'b1;
        accept(16'hFFFF, 1'b1);
        d = 16'h0004;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_valid !== 1'b1 || a !== 4'(i) || last !== (i == 15) || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_beat%0d v=%b a=%0d last=%b rdy=%b exp 1/%0d/%0d/0",
                         i, out_valid, a, last, in_ready, i, (i == 15));
            end
            if (out_valid === 1'b1) recon |= dec4to16(a);
            step();
        end
        total++;
        if (recon !== 16'hFFFF) begin
            bad++;
            $display("FAIL b2b_recon1 got=%h exp=ffff", recon);
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_bubble rdy=%b v=%b exp 1/0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        recon    = '0;
        total++;
        if (out_valid !== 1'b1 || a !== 4'd2 || last !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second v=%b a=%0d last=%b exp 1/2/1", out_valid, a, last);
        end
        if (out_valid === 1'b1) recon |= dec4to16(a);
        step();
        total++;
        if (recon !== 16'h0004 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_recon2 got=%h v=%b exp 0004/0", recon, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b1;
        accept(16'h00F0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || a !== 4'd4) begin
            bad++;
            $display("FAIL rmid_first v=%b a=%0d exp 1/4", out_valid, a);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || a !== 4'd0 || last !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async v=%b a=%0d last=%b exp 0/0/0", out_valid, a, last);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_release rdy=%b v=%b exp 1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rmid_no_leftover got=%0d exp=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
